axis_frame_reader: RTL and testbench

- AXI-Stream frame transmitter. It reads a command-specified block of words from a synchronous, 1-cycle-latency memory port and emits them as one AXIS frame, with tlast on the final beat.
- It is the source end of the stream that feeds the team's AXIS FIFO/pipeline receivers. It honours full tready backpressure without data loss.
- Read issue is credit-gated against a 2-entry output buffer, so memory latency never overruns the buffer.

---
 rtl/axis_frame_reader_if.sv | 37 +++
 rtl/axis_frame_reader.sv | 187 ++++++++++++++++++
 tb/tb_axis_frame_reader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_reader_if
// Brief    : Command, memory-read and AXI-Stream bundle for axis_frame_reader.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_frame_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  cmd_valid;
  logic                  cmd_ready;

  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  // master: the frame reader itself; slave: command source, memory and sink
  modport master (
    input  cmd_addr, cmd_len, cmd_valid, mem_rdata, m_axis_tready,
    output cmd_ready, mem_en, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output cmd_addr, cmd_len, cmd_valid, mem_rdata, m_axis_tready,
    input  cmd_ready, mem_en, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface
`default_nettype wire

// File: rtl/axis_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_reader
// Brief    : Reads a block of words from a 1-cycle-latency memory and emits
//            it as one AXI-Stream frame, credit-gated by a 2-entry buffer.
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 16
) (
  input  wire logic            aclk,
  input  wire logic            aresetn,
  axis_frame_reader_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 len_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [LEN_WIDTH-1:0]       rem_q, rem_d;
  logic                       infl_q, infl_d;
  logic                       infl_last_q, infl_last_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic [1:0][DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [1:0]                 buf_last_q, buf_last_d;
  logic                       done_q, done_d;
  logic                       len_err_q, len_err_d;

  logic       cmd_ready_w;
  logic       issue_w;
  logic       busy_w;
  logic       tvalid_w;
  logic       pop_w;
  logic       cmd_hs_w;
  logic       cmd_zero_w;
  logic       wr_idx_w;
  logic [2:0] occ_w;

  assign tvalid_w   = aresetn && (cnt_q != 2'd0);
  assign pop_w      = tvalid_w && bus.m_axis_tready;
  assign cmd_hs_w   = cmd_ready_w && bus.cmd_valid;
  assign cmd_zero_w = (bus.cmd_len == '0);

  // Slots still claimed once this cycle's pop leaves; an issue needs one free.
  assign occ_w = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop_w};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_hs_w && !cmd_zero_w) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (issue_w && (rem_q == LEN_WIDTH'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop_w && buf_last_q[0]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready_w = 1'b0;
    issue_w     = 1'b0;
    busy_w      = 1'b0;
    if (aresetn) begin
      busy_w = (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE:  cmd_ready_w = 1'b1;
        S_RUN:   issue_w     = (rem_q != '0) && (occ_w < 3'd2);
        S_DRAIN: issue_w     = 1'b0;
        default: issue_w     = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: address/length counters, in-flight tag, buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d      = addr_q;
    rem_d       = rem_q;
    infl_d      = issue_w;
    infl_last_d = issue_w && (rem_q == LEN_WIDTH'(1));
    done_d      = pop_w && buf_last_q[0];
    len_err_d   = cmd_hs_w && cmd_zero_w;

    if (cmd_hs_w && !cmd_zero_w) begin
      addr_d = bus.cmd_addr;
      rem_d  = bus.cmd_len;
    end else if (issue_w) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      rem_d  = rem_q - LEN_WIDTH'(1);
    end

    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    if (pop_w) begin
      buf_data_d[0] = buf_data_q[1];
      buf_last_d[0] = buf_last_q[1];
      buf_data_d[1] = '0;
      buf_last_d[1] = 1'b0;
    end

    // Returning read lands in the first slot that is free after the pop.
    wr_idx_w = pop_w ? (cnt_q == 2'd2) : (cnt_q == 2'd1);
    if (infl_q) begin
      buf_data_d[wr_idx_w] = bus.mem_rdata;
      buf_last_d[wr_idx_w] = infl_last_q;
    end

    cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop_w};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      addr_q      <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      buf_data_q  <= '0;
      buf_last_q  <= '0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      done_q      <= done_d;
      len_err_q   <= len_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive; everything reads zero while reset is held
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready     = cmd_ready_w;
  assign bus.mem_en        = issue_w;
  assign bus.mem_addr      = issue_w ? addr_q : '0;
  assign bus.m_axis_tvalid = tvalid_w;
  assign bus.m_axis_tdata  = aresetn ? buf_data_q[0] : '0;
  assign bus.m_axis_tlast  = aresetn && buf_last_q[0];
  assign busy              = busy_w;
  assign done              = aresetn && done_q;
  assign len_err           = aresetn && len_err_q;

  a_credit : assert property (@(posedge aclk) disable iff (!aresetn)
    (({1'b0, cnt_q} + {2'b00, infl_q}) <= 3'd2));

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_frame_reader
// Brief    : Directed scoreboard bench for axis_frame_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_frame_reader;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic busy, done, len_err;

  axis_frame_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  axis_frame_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .len_err (len_err)
  );

  always #5 aclk = ~aclk;

  // Synchronous memory with one-cycle read latency, mem[i] = i
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
  always @(posedge aclk) if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tr_mode = 0;

  beat_t         exp_q[$];
  logic [AW-1:0] addr_exp_q[$];
  beat_t         e;

  int   beat_cnt = 0, men_cnt = 0, done_cnt = 0, lerr_cycles = 0, lerr_cyc = -1;
  bit   pend_done = 0, stall_prev = 0, arm_tv = 0, arm_men = 0;
  logic [DW-1:0] stall_data;
  logic          stall_last;
  int   first_tv_cyc = -1, first_men_cyc = -1, last_beat_cyc = -1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (tr_mode)
        0:       bus.m_axis_tready = 1'b1;
        1:       bus.m_axis_tready = ~bus.m_axis_tready;
        default: bus.m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a handshake
  initial forever begin
    @(negedge aclk);
    if (!aresetn) begin
      pend_done  = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("hold_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        check("hold_tdata", 64'(bus.m_axis_tdata), 64'(stall_data));
        check("hold_tlast", 64'(bus.m_axis_tlast), 64'(stall_last));
      end
      if (pend_done) begin
        check("done_pulse", 64'(done), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        if (done) done_cnt++;
        pend_done = 0;
      end else if (done) begin
        flag_fail("done_spurious");
      end
      if (len_err) begin
        lerr_cycles++;
        lerr_cyc = cyc;
      end
      if (bus.mem_en) begin
        men_cnt++;
        if (arm_men) begin first_men_cyc = cyc; arm_men = 0; end
        if (addr_exp_q.size() == 0) flag_fail("mem_en_unexpected");
        else check("mem_addr", 64'(bus.mem_addr), 64'(addr_exp_q.pop_front()));
      end
      stall_prev = 0;
      if (bus.m_axis_tvalid) begin
        if (arm_tv) begin first_tv_cyc = cyc; arm_tv = 0; end
        if (bus.m_axis_tready) begin
          if (exp_q.size() == 0) begin
            flag_fail("beat_unexpected");
          end else begin
            e = exp_q.pop_front();
            check("tdata", 64'(bus.m_axis_tdata), 64'(e.data));
            check("tlast", 64'(bus.m_axis_tlast), 64'(e.last));
          end
          beat_cnt++;
          if (bus.m_axis_tlast) begin
            pend_done     = 1;
            last_beat_cyc = cyc;
          end
        end else begin
          stall_prev = 1;
          stall_data = bus.m_axis_tdata;
          stall_last = bus.m_axis_tlast;
        end
      end
    end
  end

  task automatic send_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len, output int hs);
    beat_t         b;
    logic [AW-1:0] a;
    bit            got = 0;
    hs = -1;
    for (int i = 0; i < int'(len); i++) begin
      a      = addr + AW'(i);
      b.data = DW'(a);
      b.last = (i == int'(len) - 1);
      addr_exp_q.push_back(a);
      exp_q.push_back(b);
    end
    if (len != '0) begin
      arm_tv  = 1;
      arm_men = 1;
    end
    @(posedge aclk);
    #1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge aclk);
      if (bus.cmd_ready) begin
        got = 1;
        hs  = cyc;
      end
    end
    if (!got) flag_fail("cmd_accept_timeout");
    @(posedge aclk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_frame(input int target_done);
    bit ok = 0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(posedge aclk);
      if (done_cnt >= target_done) ok = 1;
    end
    if (!ok) flag_fail("frame_timeout");
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("addr_queue_empty", 64'(addr_exp_q.size()), 64'd0);
    @(negedge aclk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    int hs, m0, b0, d0, l0;
    bit ok;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_mem_en", 64'(bus.mem_en), 64'd0);
    check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Basic frame: latency and back-to-back beats
    send_cmd(10'h010, 16'd4, hs);
    wait_frame(1);
    check("lat_mem_en", 64'(first_men_cyc - hs), 64'd1);
    check("lat_tvalid", 64'(first_tv_cyc - hs), 64'd3);
    check("lat_tlast", 64'(last_beat_cyc - hs), 64'd6);

    // Backpressure: alternating ready, then random stalls
    tr_mode = 1;
    b0 = beat_cnt;
    send_cmd(10'h100, 16'd8, hs);
    wait_frame(2);
    check("bp_alt_beats", 64'(beat_cnt - b0), 64'd8);
    tr_mode = 2;
    b0 = beat_cnt;
    send_cmd(10'h1F0, 16'd8, hs);
    wait_frame(3);
    check("bp_rand_beats", 64'(beat_cnt - b0), 64'd8);
    tr_mode = 0;

    // Single beat
    m0 = men_cnt;
    b0 = beat_cnt;
    send_cmd(10'h005, 16'd1, hs);
    wait_frame(4);
    check("single_mem_en", 64'(men_cnt - m0), 64'd1);
    check("single_beats", 64'(beat_cnt - b0), 64'd1);

    // Address wrap
    send_cmd(10'h3FE, 16'd4, hs);
    wait_frame(5);

    // Illegal length
    m0 = men_cnt; b0 = beat_cnt; d0 = done_cnt; l0 = lerr_cycles;
    send_cmd(10'h030, 16'd0, hs);
    repeat (8) @(posedge aclk);
    @(negedge aclk);
    check("zl_len_err_cycles", 64'(lerr_cycles - l0), 64'd1);
    check("zl_len_err_timing", 64'(lerr_cyc - hs), 64'd1);
    check("zl_mem_en", 64'(men_cnt - m0), 64'd0);
    check("zl_beats", 64'(beat_cnt - b0), 64'd0);
    check("zl_done", 64'(done_cnt - d0), 64'd0);
    check("zl_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("zl_busy", 64'(busy), 64'd0);

    // Reset mid-frame after 3 beats
    b0 = beat_cnt;
    send_cmd(10'h040, 16'd8, hs);
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge aclk);
      if (beat_cnt >= b0 + 3) ok = 1;
    end
    if (!ok) flag_fail("midrst_beats_timeout");
    #1 aresetn = 1'b0;
    exp_q.delete();
    addr_exp_q.delete();
    arm_tv = 0;
    arm_men = 0;
    @(negedge aclk);
    check("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge aclk);
    check("midrst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    d0 = done_cnt;
    repeat (2) begin
      @(negedge aclk);
      check("postrst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      check("postrst_busy", 64'(busy), 64'd0);
      check("postrst_done", 64'(done), 64'd0);
    end
    b0 = beat_cnt;
    send_cmd(10'h020, 16'd2, hs);
    wait_frame(d0 + 1);
    check("postrst_beats", 64'(beat_cnt - b0), 64'd2);

    @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
